// File: rtl/fifo_consumer_packer_if.sv
// Handshake bundle between the FIFO consumer port, the packer and the wide sink.
// pk_parity exists only when FIFO_PACK_PARITY_EN is defined.
interface fifo_consumer_packer_if #(
  parameter int T_SIZE = 3,
  parameter int PACK   = 4
);
  localparam int WORD_W = T_SIZE * PACK;
  localparam int CNT_W  = $clog2(PACK + 1);

  logic              f2c_irdy;
  logic [T_SIZE-1:0] data_out;
  logic              c2f_trdy;
  logic              flush;
  logic              pk_valid;
  logic [WORD_W-1:0] pk_data;
  logic [CNT_W-1:0]  pk_count;
  logic              pk_ready;
`ifdef FIFO_PACK_PARITY_EN
  logic              pk_parity;
`endif

  // The packer is the slave; the environment (FIFO + sink) is the master.
  modport slave (
    input  f2c_irdy,
    input  data_out,
    input  flush,
    input  pk_ready,
    output c2f_trdy,
    output pk_valid,
    output pk_data,
    output pk_count
`ifdef FIFO_PACK_PARITY_EN
    ,
    output pk_parity
`endif
  );

  modport master (
    output f2c_irdy,
    output data_out,
    output flush,
    output pk_ready,
    input  c2f_trdy,
    input  pk_valid,
    input  pk_data,
    input  pk_count
`ifdef FIFO_PACK_PARITY_EN
    ,
    input  pk_parity
`endif
  );

endinterface

// File: rtl/fifo_consumer_packer.sv
// Drains T_SIZE-bit FIFO items and packs PACK of them into one wide valid/ready word.
// Optional even-parity output is enabled by defining FIFO_PACK_PARITY_EN.
module fifo_consumer_packer #(
  parameter int T_SIZE = 3,
  parameter int PACK   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_consumer_packer_if.slave bus
);
  localparam int WORD_W = T_SIZE * PACK;
  localparam int CNT_W  = $clog2(PACK + 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] asm_take;
  logic              trdy;
  logic              take;
  logic              last_slot;

  // trdy must never look at f2c_irdy, otherwise a loop forms through the FIFO.
  always_comb begin
    trdy = 1'b0;
    if (!rst) begin
      trdy = (state_q == FILL) ? 1'b1 : bus.pk_ready;
    end
  end

  assign take      = bus.f2c_irdy && trdy;
  assign last_slot = (idx_q == CNT_W'(PACK - 1));

  always_comb begin
    asm_take = asm_q;
    for (int i = 0; i < PACK; i++) begin
      if (take && (idx_q == CNT_W'(i))) begin
        asm_take[i*T_SIZE +: T_SIZE] = bus.data_out;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    word_d  = word_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        if (take && last_slot) begin
          state_d = HOLD;
          word_d  = asm_take;
          count_d = CNT_W'(PACK);
          idx_d   = '0;
          asm_d   = '0;
        end else if (bus.flush && ((idx_q != '0) || take)) begin
          // An item arriving in the flush cycle still belongs to this word.
          state_d = HOLD;
          word_d  = asm_take;
          count_d = idx_q + CNT_W'(take);
          idx_d   = '0;
          asm_d   = '0;
        end else if (take) begin
          asm_d = asm_take;
          idx_d = idx_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.pk_ready) begin
          state_d = FILL;
          if (take) begin
            asm_d = {{(WORD_W - T_SIZE){1'b0}}, bus.data_out};
            idx_d = CNT_W'(1);
          end else begin
            asm_d = '0;
            idx_d = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
        asm_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign bus.c2f_trdy = trdy;
  assign bus.pk_valid = (state_q == HOLD);
  assign bus.pk_data  = word_q;
  assign bus.pk_count = count_q;

`ifdef FIFO_PACK_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^word_d;
    end
  end

  assign bus.pk_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_consumer_packer.sv
// Scoreboard bench for fifo_consumer_packer: a queue-fed FIFO model drives items,
// expected words are queued as stimulus is planned and popped on each word transfer.
module tb_fifo_consumer_packer;
  localparam int TS = 3;
  localparam int PK = 4;
  localparam int WW = TS * PK;
  localparam int CW = $clog2(PK + 1);

  typedef struct {
    logic [WW-1:0] data;
    logic [CW-1:0] count;
    logic          parity;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails = 0;

  exp_t          expQ[$];
  logic [TS-1:0] srcQ[$];

  always #5 clk = ~clk;

  fifo_consumer_packer_if #(.T_SIZE(TS), .PACK(PK)) pkIf ();

  fifo_consumer_packer #(.T_SIZE(TS), .PACK(PK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pkIf)
  );

  function automatic exp_t mkExp(input logic [WW-1:0] d, input logic [CW-1:0] c);
    exp_t e;
    e.data  = d;
    e.count = c;
`ifdef FIFO_PACK_PARITY_EN
    e.parity = ^d;
`else
    e.parity = 1'b0;
`endif
    return e;
  endfunction

  // One clock: present the FIFO head, sample at the falling edge, pop on a take.
  task automatic step(output bit xfer, output bit trdy, output bit valid,
                      output logic [WW-1:0] d, output logic [CW-1:0] c, output logic p);
    pkIf.f2c_irdy = (srcQ.size() > 0);
    pkIf.data_out = (srcQ.size() > 0) ? srcQ[0] : '0;
    @(negedge clk);
    trdy  = pkIf.c2f_trdy;
    valid = pkIf.pk_valid;
    xfer  = pkIf.pk_valid && pkIf.pk_ready;
    d     = pkIf.pk_data;
    c     = pkIf.pk_count;
`ifdef FIFO_PACK_PARITY_EN
    p = pkIf.pk_parity;
`else
    p = 1'b0;
`endif
    if (pkIf.f2c_irdy && pkIf.c2f_trdy) void'(srcQ.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pkIf.f2c_irdy = 1'b0;
    pkIf.data_out = '0;
    pkIf.flush    = 1'b0;
    pkIf.pk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pkIf.pk_valid !== 1'b0 || pkIf.pk_count !== '0 || pkIf.pk_data !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got valid %b count %0d data %h, required 0 0 000",
               pkIf.pk_valid, pkIf.pk_count, pkIf.pk_data);
    end
    checks++;
    if (pkIf.c2f_trdy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_trdy: got %b, required 0", pkIf.c2f_trdy);
    end
`ifdef FIFO_PACK_PARITY_EN
    checks++;
    if (pkIf.pk_parity !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_parity: got %b, required 0", pkIf.pk_parity);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (pkIf.c2f_trdy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL post_reset_trdy: got %b, required 1", pkIf.c2f_trdy);
    end
  endtask

  task automatic test_basic_pack();
    bit xfer, trdy, valid;
    logic [WW-1:0] d;
    logic [CW-1:0] c;
    logic p;
    exp_t e;
    int validCycles = 0;
    int firstAt = -1;
    for (int v = 1; v <= 4; v++) srcQ.push_back(TS'(v));
    expQ.push_back(mkExp(12'h8D1, 3'd4));
    pkIf.pk_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(xfer, trdy, valid, d, c, p);
      if (valid) begin
        validCycles++;
        if (firstAt < 0) firstAt = i;
      end
      if (xfer) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL basic_word: got unexpected word %h count %0d, required none", d, c);
        end else begin
          e = expQ.pop_front();
          if (d !== e.data || c !== e.count || p !== e.parity) begin
            fails++;
            $display("[TB] FAIL basic_word: got %h/%0d/%b, required %h/%0d/%b",
                     d, c, p, e.data, e.count, e.parity);
          end
        end
      end
    end
    checks++;
    if (validCycles != 1 || firstAt != 5) begin
      fails++;
      $display("[TB] FAIL basic_latency: got %0d valid cycles first at %0d, required 1 at 5",
               validCycles, firstAt);
    end
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL basic_drain: got %0d words outstanding, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_flush();
    bit xfer, trdy, valid;
    logic [WW-1:0] d;
    logic [CW-1:0] c;
    logic p;
    exp_t e;
    int validCycles = 0;
    int firstAt = -1;
    srcQ.push_back(3'd5);
    srcQ.push_back(3'd6);
    expQ.push_back(mkExp(12'h035, 3'd2));
    pkIf.pk_ready = 1'b1;
    // Step 3 flushes the two-item word; steps 6-7 flush with nothing packed.
    for (int i = 1; i <= 10; i++) begin
      pkIf.flush = (i == 3) || (i == 6) || (i == 7);
      step(xfer, trdy, valid, d, c, p);
      if (valid) begin
        validCycles++;
        if (firstAt < 0) firstAt = i;
      end
      if (xfer) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL flush_word: got unexpected word %h count %0d, required none", d, c);
        end else begin
          e = expQ.pop_front();
          if (d !== e.data || c !== e.count || p !== e.parity) begin
            fails++;
            $display("[TB] FAIL flush_word: got %h/%0d/%b, required %h/%0d/%b",
                     d, c, p, e.data, e.count, e.parity);
          end
        end
      end
    end
    pkIf.flush = 1'b0;
    checks++;
    if (validCycles != 1 || firstAt != 4) begin
      fails++;
      $display("[TB] FAIL flush_latency: got %0d valid cycles first at %0d, required 1 at 4",
               validCycles, firstAt);
    end
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL flush_drain: got %0d words outstanding, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_backpressure();
    bit xfer, trdy, valid;
    logic [WW-1:0] d;
    logic [CW-1:0] c;
    logic p;
    exp_t e;
    logic [TS-1:0] items[8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    foreach (items[k]) srcQ.push_back(items[k]);
    expQ.push_back(mkExp(12'h8D1, 3'd4));
    expQ.push_back(mkExp(12'h1F5, 3'd4));
    for (int i = 1; i <= 20; i++) begin
      pkIf.pk_ready = (i >= 10);
      step(xfer, trdy, valid, d, c, p);
      if (i >= 5 && i <= 9) begin
        checks++;
        if (trdy !== 1'b0 || valid !== 1'b1 || d !== 12'h8D1 || c !== 3'd4) begin
          fails++;
          $display("[TB] FAIL hold_stable cycle %0d: got trdy %b valid %b data %h count %0d, required 0 1 8d1 4",
                   i, trdy, valid, d, c);
        end
      end
      if (i == 10) begin
        checks++;
        if (trdy !== 1'b1) begin
          fails++;
          $display("[TB] FAIL release_trdy: got %b, required 1", trdy);
        end
      end
      if (xfer) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL bp_word: got unexpected word %h count %0d, required none", d, c);
        end else begin
          e = expQ.pop_front();
          if (d !== e.data || c !== e.count || p !== e.parity) begin
            fails++;
            $display("[TB] FAIL bp_word: got %h/%0d/%b, required %h/%0d/%b",
                     d, c, p, e.data, e.count, e.parity);
          end
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL bp_drain: got %0d words outstanding, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_streaming();
    bit xfer, trdy, valid;
    logic [WW-1:0] d;
    logic [CW-1:0] c;
    logic p;
    exp_t e;
    logic [WW-1:0] w;
    logic [TS-1:0] item;
    int words = 0;
    for (int k = 0; k < 4; k++) begin
      w = '0;
      for (int s = 0; s < PK; s++) begin
        item = TS'($urandom_range(0, 7));
        srcQ.push_back(item);
        w[s*TS +: TS] = item;
      end
      expQ.push_back(mkExp(w, 3'd4));
    end
    pkIf.pk_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(xfer, trdy, valid, d, c, p);
      if (i <= 16) begin
        checks++;
        if (trdy !== 1'b1) begin
          fails++;
          $display("[TB] FAIL stream_trdy cycle %0d: got %b, required 1", i, trdy);
        end
      end
      if (i == 16) begin
        checks++;
        if (srcQ.size() != 0) begin
          fails++;
          $display("[TB] FAIL stream_no_bubble: got %0d items left after 16 cycles, required 0",
                   srcQ.size());
        end
      end
      if (xfer) begin
        words++;
        checks++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL stream_word: got unexpected word %h count %0d, required none", d, c);
        end else begin
          e = expQ.pop_front();
          if (d !== e.data || c !== e.count || p !== e.parity) begin
            fails++;
            $display("[TB] FAIL stream_word: got %h/%0d/%b, required %h/%0d/%b",
                     d, c, p, e.data, e.count, e.parity);
          end
        end
      end
    end
    checks++;
    if (words != 4 || expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL stream_words: got %0d words, %0d outstanding, required 4 and 0",
               words, expQ.size());
      expQ.delete();
    end
    srcQ.delete();
  endtask

  task automatic test_reset_mid_word();
    bit xfer, trdy, valid;
    logic [WW-1:0] d;
    logic [CW-1:0] c;
    logic p;
    exp_t e;
    int early = 0;
    srcQ.push_back(3'd1);
    srcQ.push_back(3'd2);
    pkIf.pk_ready = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step(xfer, trdy, valid, d, c, p);
      if (valid) early++;
    end
    checks++;
    if (early != 0) begin
      fails++;
      $display("[TB] FAIL mid_word_premature: got %0d valid cycles, required 0", early);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pkIf.pk_valid !== 1'b0 || pkIf.pk_count !== '0 || pkIf.pk_data !== '0 || pkIf.c2f_trdy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: got valid %b count %0d data %h trdy %b, required 0 0 000 0",
               pkIf.pk_valid, pkIf.pk_count, pkIf.pk_data, pkIf.c2f_trdy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) srcQ.push_back(3'd7);
    expQ.push_back(mkExp(12'hFFF, 3'd4));
    for (int i = 1; i <= 10; i++) begin
      step(xfer, trdy, valid, d, c, p);
      if (xfer) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL after_reset_word: got unexpected word %h count %0d, required none", d, c);
        end else begin
          e = expQ.pop_front();
          if (d !== e.data || c !== e.count || p !== e.parity) begin
            fails++;
            $display("[TB] FAIL after_reset_word: got %h/%0d/%b, required %h/%0d/%b",
                     d, c, p, e.data, e.count, e.parity);
          end
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL after_reset_drain: got %0d words outstanding, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_pack();
    test_flush();
    test_backpressure();
    test_streaming();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
